// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler: synchronises per-source events, latches them as pending and issues one
// instruction at a time over valid/ack. Define ROUND_ROBIN_EN for rotating priority.
module interrupt_scheduler #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DROP_W  = 8,
    localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_event,
    input  logic [NUM_SRC*INSTR_W-1:0] src_instr,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic                       cpu_ack,
    output logic                       irq_valid,
    output logic [INSTR_W-1:0]         irq_instruction,
    output logic [SRC_W-1:0]           irq_src,
    output logic [NUM_SRC-1:0]         pending,
    output logic [DROP_W-1:0]          drop_count
);

    localparam int unsigned SUM_W = DROP_W + SRC_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e              state_q, state_d;
    logic [NUM_SRC-1:0]  sync1_q, sync2_q, sync3_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [DROP_W-1:0]   drop_count_q, drop_count_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [NUM_SRC-1:0]  rise, set_vec, clr_vec, drop_vec, eligible;
    logic [SRC_W:0]      drop_n;
    logic [SUM_W-1:0]    drop_sum;
    logic                grant_found;
    logic [SRC_W-1:0]    grant_idx;
    logic [INSTR_W-1:0]  instr_arr [NUM_SRC];
`ifdef ROUND_ROBIN_EN
    logic [SRC_W-1:0]    last_q, last_d;
    int unsigned         rr_idx;
`endif

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            instr_arr[i] = src_instr[i*INSTR_W +: INSTR_W];
        end
    end

    // Two-flop synchroniser; sync3 holds the previous synchronised level for edge detection.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= src_event;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~sync3_q;
    assign eligible = pending_q & src_mask;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef ROUND_ROBIN_EN
        rr_idx = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = 32'(last_q) + 32'(k) + 32'd1;
            if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
            if (!grant_found && eligible[rr_idx[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx[SRC_W-1:0];
            end
        end
`else
        // Descending scan so the lowest eligible index is the last writer.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(i);
            end
        end
`endif
    end

    always_comb begin
        clr_vec = '0;
        if (state_q == StIssue && cpu_ack) clr_vec[src_q] = 1'b1;
        set_vec   = rise & src_mask;
        // A fresh edge coinciding with the clear re-arms the source instead of dropping.
        drop_vec  = set_vec & pending_q & ~clr_vec;
        pending_d = (pending_q & ~clr_vec) | set_vec;

        drop_n = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_n = drop_n + (SRC_W + 1)'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_count_q) + SUM_W'(drop_n);
        if (|drop_sum[SUM_W-1:DROP_W]) drop_count_d = '1;
        else                           drop_count_d = drop_sum[DROP_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        src_d   = src_q;
`ifdef ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d = StIssue;
                    instr_d = instr_arr[grant_idx];
                    src_d   = grant_idx;
                end
            end
            StIssue: begin
                if (cpu_ack) begin
                    state_d = StGap;
`ifdef ROUND_ROBIN_EN
                    last_d  = src_q;
`endif
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            drop_count_q <= '0;
            instr_q      <= '0;
            src_q        <= '0;
`ifdef ROUND_ROBIN_EN
            last_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            drop_count_q <= drop_count_d;
            instr_q      <= instr_d;
            src_q        <= src_d;
`ifdef ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign irq_valid       = (state_q == StIssue);
    assign irq_instruction = irq_valid ? instr_q : '0;
    assign irq_src         = src_q;
    assign pending         = pending_q;
    assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// tb_interrupt_scheduler: directed scenarios plus a randomized run checked against a
// cycle-level reference model of the scheduling rules.
module tb_interrupt_scheduler;

`ifdef ROUND_ROBIN_EN
    localparam int FIRST_SRC = 1;
`else
    localparam int FIRST_SRC = 0;
`endif

    logic         sysclk = 1'b0;
    logic         reset;
    logic [3:0]   src_event;
    logic [127:0] src_instr;
    logic [3:0]   src_mask;
    logic         cpu_ack;
    logic         irq_valid;
    logic [31:0]  irq_instruction;
    logic [1:0]   irq_src;
    logic [3:0]   pending;
    logic [7:0]   drop_count;

    int checks   = 0;
    int failures = 0;

    interrupt_scheduler #(
        .NUM_SRC(4),
        .INSTR_W(32),
        .DROP_W (8)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .src_event      (src_event),
        .src_instr      (src_instr),
        .src_mask       (src_mask),
        .cpu_ack        (cpu_ack),
        .irq_valid      (irq_valid),
        .irq_instruction(irq_instruction),
        .irq_src        (irq_src),
        .pending        (pending),
        .drop_count     (drop_count)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: event samples at the last three edges ([0] newest), pending set,
    // drop total, and whether an instruction is outstanding or in its cool-down cycle.
    logic [3:0]  hist [3];
    logic [3:0]  m_pend;
    int          m_drop;
    bit          m_busy;
    int          m_cool;
    int          m_src;
    int          m_last;
    logic [31:0] m_instr;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_pend  = '0;
        m_drop  = 0;
        m_busy  = 0;
        m_cool  = 0;
        m_src   = 0;
        m_last  = 0;
        m_instr = '0;
    endfunction

    function automatic int pick(input logic [3:0] elig, input int last);
        for (int k = 0; k < 4; k++) begin
            int idx;
`ifdef ROUND_ROBIN_EN
            idx = (last + 1 + k) % 4;
`else
            idx = k;
`endif
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    // Applies the scheduling rules to the inputs present just before the coming edge.
    function automatic void model_tick();
        logic [3:0] rise, clr, set_v;
        int g;
        if (!reset) begin
            model_reset();
            return;
        end
        rise    = hist[1] & ~hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = src_event;
        clr     = '0;
        if (m_busy) begin
            if (cpu_ack) begin
                clr[m_src] = 1'b1;
                m_busy = 0;
                m_cool = 1;
                m_last = m_src;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            g = pick(m_pend & src_mask, m_last);
            if (g >= 0) begin
                m_busy  = 1;
                m_src   = g;
                m_instr = src_instr[g*32 +: 32];
            end
        end
        set_v = rise & src_mask;
        for (int i = 0; i < 4; i++) begin
            if (set_v[i] && m_pend[i] && !clr[i] && m_drop < 255) m_drop++;
        end
        m_pend = (m_pend & ~clr) | set_v;
    endfunction

    task automatic step();
        model_tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        src_event = '0;
        cpu_ack   = 1'b0;
        src_mask  = 4'hF;
        src_instr = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (irq_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", irq_valid);
        end
        checks++;
        if (irq_instruction !== 32'h0) begin
            failures++; $display("FAIL reset_instr: got %h want 0", irq_instruction);
        end
        checks++;
        if (irq_src !== 2'd0 || pending !== 4'h0 || drop_count !== 8'h0) begin
            failures++;
            $display("FAIL reset_state: src=%0d pend=%b drop=%h want 0/0000/00",
                     irq_src, pending, drop_count);
        end
    endtask

    task automatic test_single_event();
        int issues = 0;
        do_reset();
        cpu_ack   = 1'b1;
        src_instr[31:0] = 32'hA5A5_0001;
        src_event = 4'b0001;
        step();                      // cycle 1
        src_event = 4'b0000;
        step();                      // cycle 2
        checks++;
        if (pending !== 4'b0000) begin
            failures++; $display("FAIL single_early_pend: got %b want 0000", pending);
        end
        step();                      // cycle 3
        checks++;
        if (pending !== 4'b0001 || irq_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pend_c3: pend=%b valid=%b want 0001/0", pending, irq_valid);
        end
        step();                      // cycle 4
        checks++;
        if (irq_valid !== 1'b1 || irq_instruction !== 32'hA5A5_0001 || irq_src !== 2'd0) begin
            failures++;
            $display("FAIL single_issue_c4: valid=%b instr=%h src=%0d want 1/a5a50001/0",
                     irq_valid, irq_instruction, irq_src);
        end
        if (irq_valid) issues++;
        step();                      // cycle 5
        checks++;
        if (irq_valid !== 1'b0 || irq_instruction !== 32'h0 || pending !== 4'h0) begin
            failures++;
            $display("FAIL single_gap: valid=%b instr=%h pend=%b want 0/0/0000",
                     irq_valid, irq_instruction, pending);
        end
        repeat (10) begin
            step();
            if (irq_valid) issues++;
        end
        checks++;
        if (issues != 1) begin
            failures++; $display("FAIL single_issue_count: got %0d want 1", issues);
        end
    endtask

    task automatic test_simultaneous();
        int second;
        second = (FIRST_SRC == 0) ? 1 : 0;
        do_reset();
        src_event = 4'b0011;
        step();
        src_event = 4'b0000;
        repeat (3) step();           // cycle 4
        checks++;
        if (irq_valid !== 1'b1 || irq_src !== 2'(FIRST_SRC) ||
            irq_instruction !== 32'h1000_0000 + 32'(FIRST_SRC) || pending !== 4'b0011) begin
            failures++;
            $display("FAIL simul_first: valid=%b src=%0d instr=%h pend=%b want src %0d",
                     irq_valid, irq_src, irq_instruction, pending, FIRST_SRC);
        end
        repeat (4) step();
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0 || pending !== 4'(1 << second)) begin
            failures++;
            $display("FAIL simul_after_ack: valid=%b pend=%b want 0/%b",
                     irq_valid, pending, 4'(1 << second));
        end
        step();
        checks++;
        if (irq_valid !== 1'b0) begin
            failures++; $display("FAIL simul_min_gap: got valid=%b want 0", irq_valid);
        end
        step();
        checks++;
        if (irq_valid !== 1'b1 || irq_src !== 2'(second) ||
            irq_instruction !== 32'h1000_0000 + 32'(second)) begin
            failures++;
            $display("FAIL simul_second: valid=%b src=%0d instr=%h want 1/%0d",
                     irq_valid, irq_src, irq_instruction, second);
        end
    endtask

    task automatic test_drop();
        bit stable = 1;
        do_reset();
        src_instr[63:32] = 32'hD00D_0001;
        for (int k = 0; k < 300; k++) begin
            if (k >= 3) src_instr[63:32] = $urandom();
            src_event = 4'b0010;
            step();
            if (k >= 2 && (irq_valid !== 1'b1 || irq_instruction !== 32'hD00D_0001)) stable = 0;
            src_event = 4'b0000;
            step();
            if (k >= 2 && (irq_valid !== 1'b1 || irq_instruction !== 32'hD00D_0001)) stable = 0;
            if (k == 100 || k == 255 || k == 256) begin
                checks++;
                if (drop_count !== 8'(k - 1)) begin
                    failures++;
                    $display("FAIL drop_count_k%0d: got %h want %h", k, drop_count, 8'(k - 1));
                end
            end
        end
        repeat (3) step();
        checks++;
        if (drop_count !== 8'hFF) begin
            failures++; $display("FAIL drop_saturate: got %h want ff", drop_count);
        end
        checks++;
        if (!stable || pending !== 4'b0010 || irq_src !== 2'd1) begin
            failures++;
            $display("FAIL drop_stable: stable=%0d pend=%b src=%0d want 1/0010/1",
                     stable, pending, irq_src);
        end
    endtask

    task automatic test_mask();
        bit seen_valid = 0;
        do_reset();
        src_mask  = 4'b1101;
        cpu_ack   = 1'b1;
        src_event = 4'b0010;
        step();
        src_event = 4'b0000;
        repeat (12) begin
            step();
            if (irq_valid) seen_valid = 1;
        end
        checks++;
        if (pending !== 4'h0 || seen_valid || drop_count !== 8'h0) begin
            failures++;
            $display("FAIL mask_src1: pend=%b issued=%0d drop=%h want 0000/0/00",
                     pending, seen_valid, drop_count);
        end
    endtask

    task automatic test_rearm();
        do_reset();
        src_instr[95:64] = 32'hBEEF_0002;
        src_event = 4'b0100;
        step();
        src_event = 4'b0000;
        repeat (3) step();           // cycle 4
        checks++;
        if (irq_valid !== 1'b1 || irq_src !== 2'd2) begin
            failures++; $display("FAIL rearm_first: valid=%b src=%0d want 1/2", irq_valid, irq_src);
        end
        src_event = 4'b0100;
        step();                      // cycle 5
        src_event = 4'b0000;
        step();                      // cycle 6
        cpu_ack = 1'b1;
        step();                      // cycle 7: edge lands with the ack
        cpu_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0 || pending !== 4'b0100 || drop_count !== 8'h0) begin
            failures++;
            $display("FAIL rearm_hold: valid=%b pend=%b drop=%h want 0/0100/00",
                     irq_valid, pending, drop_count);
        end
        repeat (2) step();           // cycle 9
        checks++;
        if (irq_valid !== 1'b1 || irq_src !== 2'd2 || irq_instruction !== 32'hBEEF_0002) begin
            failures++;
            $display("FAIL rearm_second: valid=%b src=%0d instr=%h want 1/2/beef0002",
                     irq_valid, irq_src, irq_instruction);
        end
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        checks++;
        if (pending !== 4'h0 || drop_count !== 8'h0) begin
            failures++;
            $display("FAIL rearm_done: pend=%b drop=%h want 0000/00", pending, drop_count);
        end
    endtask

    task automatic test_async_reset();
        bit seen_valid = 0;
        do_reset();
        src_event = 4'b0011;
        step();
        src_event = 4'b0000;
        repeat (3) step();
        checks++;
        if (irq_valid !== 1'b1 || pending !== 4'b0011) begin
            failures++;
            $display("FAIL areset_setup: valid=%b pend=%b want 1/0011", irq_valid, pending);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (irq_valid !== 1'b0 || pending !== 4'h0 || irq_instruction !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate: valid=%b pend=%b instr=%h want 0/0000/0",
                     irq_valid, pending, irq_instruction);
        end
        model_reset();
        @(posedge sysclk);
        #1;
        reset = 1'b1;
        repeat (10) begin
            step();
            if (irq_valid) seen_valid = 1;
        end
        checks++;
        if (seen_valid || pending !== 4'h0) begin
            failures++;
            $display("FAIL areset_quiet: issued=%0d pend=%b want 0/0000", seen_valid, pending);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src_event = src_event ^ 4'($urandom());
            if ($urandom_range(0, 49) == 0) src_mask = 4'($urandom()) | 4'($urandom());
            cpu_ack   = ($urandom_range(0, 2) == 0);
            src_instr = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            checks++;
            if (irq_valid !== m_busy ||
                irq_instruction !== (m_busy ? m_instr : 32'h0) ||
                irq_src !== 2'(m_src) || pending !== m_pend || drop_count !== 8'(m_drop)) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_c%0d: got v=%b i=%h s=%0d p=%b d=%h want v=%b i=%h s=%0d p=%b d=%h",
                             c, irq_valid, irq_instruction, irq_src, pending, drop_count,
                             m_busy, m_busy ? m_instr : 32'h0, m_src, m_pend, 8'(m_drop));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_event();
        test_simultaneous();
        test_drop();
        test_mask();
        test_rearm();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
